dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: DATA_W, 32, data word width (only 32 supported).
REQ-002 Parameter: DM_ADDRESS, 9, byte address width; word index width is DM_ADDRESS-2.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: MemRead  input  1  load request from the MEM stage.
REQ-006 Port: MemWrite  input  1  store request from the MEM stage.
REQ-007 Port: addr  input  DM_ADDRESS  byte address of the access.
REQ-008 Port: wr_data  input  DATA_W  store data; the byte or halfword is taken from the low bits.
REQ-009 Port: func3  input  3  RISC-V width code (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-010 Port: rd_data  output  DATA_W  load result, sign- or zero-extended.
REQ-011 Port: mem_stall  output  1  high means the pipeline holds the MEM stage and everything upstream.
REQ-012 Port: mem_err  output  1  one-cycle pulse for a misaligned or illegal access.
REQ-013 Port: sram_re  output  1  SRAM read enable.
REQ-014 Port: sram_we  output  1  SRAM word write enable.
REQ-015 Port: sram_addr  output  DM_ADDRESS-2  SRAM word index, equal to addr[DM_ADDRESS-1:2].
REQ-016 Port: sram_wdata  output  DATA_W  SRAM write word.
REQ-017 Port: sram_rdata  input  DATA_W  SRAM read word; valid the cycle after sram_re is high.

Function
REQ-018 FSM states: IDLE, LOAD_WAIT, RMW_MERGE. The state register is the only multi-cycle state, plus the held rd_data register.
REQ-019 Requests are accepted only in IDLE. While mem_stall is high the pipeline holds MemRead, MemWrite, addr, wr_data and func3 stable.
REQ-020 MemWrite and MemRead both high: the access is treated as a store.
REQ-021 Alignment rules: H/HU need addr[0]=0; W needs addr[1:0]=0. Otherwise the access is misaligned.
REQ-022 Illegal codes: func3 3, 6 or 7 on a load; func3 other than 0, 1 or 2 on a store.
REQ-023 Misaligned or illegal access in IDLE:
- mem_err=1 for that cycle;
- no SRAM enable; mem_stall=0;
- held rd_data cleared to 0;
- state stays IDLE.
REQ-024 Legal SW in IDLE:
- same cycle: sram_we=1, sram_wdata=wr_data;
- mem_stall=0 (zero-stall store).
REQ-025 Legal load in IDLE: sram_re=1, mem_stall=1, next state LOAD_WAIT.
REQ-026 LOAD_WAIT:
- rd_data is driven combinationally from sram_rdata, selected by addr[1:0] and extended per func3;
- mem_stall=0;
- the result is captured into the held register;
- next state IDLE.
REQ-027 Legal SB/SH in IDLE: sram_re=1, mem_stall=1, next state RMW_MERGE.
REQ-028 RMW_MERGE:
- sram_we=1;
- sram_wdata = sram_rdata with the addressed byte/halfword replaced from wr_data, other bytes unchanged;
- mem_stall=0;
- next state IDLE.
REQ-029 Byte order is little-endian: byte k of a word occupies bits [8k+7:8k], with k = addr[1:0].
REQ-030 Outside LOAD_WAIT, rd_data equals the held register (last completed load, or 0).
REQ-031 No request in IDLE: sram_re=0, sram_we=0, mem_stall=0, mem_err=0.
REQ-032 sram_re and sram_we are never high in the same cycle.

Reset
REQ-033 While reset is high:
- state goes to IDLE;
- held rd_data=0;
- sram_re, sram_we, mem_stall and mem_err are 0;
- this holds in any state.
REQ-034 Reset asserted in LOAD_WAIT or RMW_MERGE aborts the access; no SRAM write is issued in that cycle.

Verification
REQ-035 SRAM word 3 preloaded with 0x808182F3, each load issued separately:
- LB 0x00F -> rd_data 0xFFFFFF80;
- LBU 0x00C -> 0x000000F3;
- LH 0x00E -> 0xFFFF8081;
- LHU 0x00E -> 0x00008081;
- each load gives exactly one stall cycle.
REQ-036 SB 0x00D, wr_data 0x123456AA:
- word 3 becomes 0x8081AAF3;
- mem_stall high 1 cycle; sram_we high 1 cycle, in RMW_MERGE.
REQ-037 SW 0x010, 0xDEADBEEF -> sram_we=1 with sram_addr=4 in the same cycle; mem_stall never asserted.
REQ-038 LW 0x00E -> mem_err pulse, rd_data 0, no SRAM enable, no stall. func3=3 load at 0x000 -> same response.
REQ-039 SH 0x00C accepted, then reset asserted in RMW_MERGE -> word 3 unchanged, all outputs 0, next request accepted normally.
REQ-040 Back-to-back LW 0x00C, SW 0x00C 0x0, LW 0x00C:
- results 0x808182F3, then 0x00000000;
- total stall cycles = 2.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the MEM stage: byte/halfword/word loads and stores
// on a word-wide synchronous SRAM, with read-modify-write for sub-word stores.
module dmem_ctrl #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  mem_stall,
    output logic                  mem_err,
    output logic                  sram_re,
    output logic                  sram_we,
    output logic [DM_ADDRESS-3:0] sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_MERGE = 2'd2
    } state_t;

    state_t             state_r, next_state_s;
    logic [DATA_W-1:0]  held_r;
    logic [DATA_W-1:0]  rd_s, wdata_s;
    logic               re_s, we_s, stall_s, err_s, capture_s, clear_s;
    logic               misaligned_s, illegal_s, bad_s;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/halfword of the old word; other lanes pass through.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wd,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] r;
        r = word;
        if (f3 == 3'd0) begin
            case (off)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                2'd3:    r[31:24] = wd[7:0];
                default: r[7:0]   = wd[7:0];
            endcase
        end else if (f3 == 3'd1) begin
            if (off[1]) r[31:16] = wd[15:0];
            else        r[15:0]  = wd[15:0];
        end else begin
            r = wd;
        end
        return r;
    endfunction

    // Classify the presented request: alignment and width-code legality.
    always_comb begin
        case (func3[1:0])
            2'b01:   misaligned_s = addr[0];
            2'b10:   misaligned_s = (addr[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
        if (MemWrite) illegal_s = (func3 > 3'd2);
        else          illegal_s = (func3 == 3'd3) || (func3 >= 3'd6);
        bad_s = (MemRead | MemWrite) & (misaligned_s | illegal_s);
    end

    // Next-state and output decode; reset forces every strobe low in any state.
    always_comb begin
        next_state_s = state_r;
        re_s         = 1'b0;
        we_s         = 1'b0;
        stall_s      = 1'b0;
        err_s        = 1'b0;
        capture_s    = 1'b0;
        clear_s      = 1'b0;
        wdata_s      = 32'd0;
        rd_s         = held_r;
        if (reset) begin
            next_state_s = IDLE;
            rd_s         = 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bad_s) begin
                        err_s   = 1'b1;
                        clear_s = 1'b1;
                    end else if (MemWrite && func3 == 3'd2) begin
                        we_s    = 1'b1;
                        wdata_s = wr_data;
                    end else if (MemWrite) begin
                        re_s         = 1'b1;
                        stall_s      = 1'b1;
                        next_state_s = RMW_MERGE;
                    end else if (MemRead) begin
                        re_s         = 1'b1;
                        stall_s      = 1'b1;
                        next_state_s = LOAD_WAIT;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                LOAD_WAIT: begin
                    rd_s         = load_extend(sram_rdata, addr[1:0], func3);
                    capture_s    = 1'b1;
                    next_state_s = IDLE;
                end
                RMW_MERGE: begin
                    we_s         = 1'b1;
                    wdata_s      = store_merge(sram_rdata, wr_data, addr[1:0], func3);
                    next_state_s = IDLE;
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Held load result: last completed load, cleared by a rejected access.
    always_ff @(posedge clk) begin
        if (reset)          held_r <= 32'd0;
        else if (capture_s) held_r <= rd_s;
        else if (clear_s)   held_r <= 32'd0;
        else                held_r <= held_r;
    end

    assign rd_data    = rd_s;
    assign mem_stall  = stall_s;
    assign mem_err    = err_s;
    assign sram_re    = re_s;
    assign sram_we    = we_s;
    assign sram_wdata = wdata_s;
    assign sram_addr  = addr[DM_ADDRESS-1:2];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed table, multi-cycle corner cases,
// and randomized traffic against a byte-level reference model.
module tb_dmem_ctrl;

    localparam int WORDS = 128;

    logic        clk = 1'b0;
    logic        reset, MemRead, MemWrite;
    logic [8:0]  addr;
    logic [31:0] wr_data, rd_data, sram_wdata, sram_rdata;
    logic [2:0]  func3;
    logic        mem_stall, mem_err, sram_re, sram_we;
    logic [6:0]  sram_addr;

    logic [31:0] sram_mem [0:WORDS-1];
    logic [31:0] ref_mem  [0:WORDS-1];
    logic [31:0] ref_held;
    logic        pre_en;
    logic [6:0]  pre_idx;
    logic [31:0] pre_val;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DATA_W(32), .DM_ADDRESS(9)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .wr_data(wr_data), .func3(func3), .rd_data(rd_data),
        .mem_stall(mem_stall), .mem_err(mem_err), .sram_re(sram_re),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    // Synchronous SRAM: read data valid the cycle after sram_re.
    always @(posedge clk) begin
        if (pre_en) sram_mem[pre_idx] <= pre_val;
        if (sram_we) sram_mem[sram_addr] <= sram_wdata;
        if (sram_re) sram_rdata <= sram_mem[sram_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [6:0] idx, input logic [31:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk); #1;
        pre_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Present one request and follow it until the pipeline is released.
    task automatic do_op(input logic rd, input logic wr, input logic [8:0] a,
                         input logic [31:0] wd, input logic [2:0] f3,
                         output int stalls, output logic err, output logic [31:0] res,
                         output int we_cnt, output int re_cnt, output logic [6:0] we_addr,
                         output logic overlap);
        logic done;
        MemRead = rd; MemWrite = wr; addr = a; wr_data = wd; func3 = f3;
        stalls = 0; err = 1'b0; res = 32'd0; we_cnt = 0; re_cnt = 0;
        we_addr = 7'd0; overlap = 1'b0; done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_err) err = 1'b1;
            if (sram_we) begin we_cnt++; we_addr = sram_addr; end
            if (sram_re) re_cnt++;
            if (sram_re && sram_we) overlap = 1'b1;
            res = rd_data;
            if (!mem_stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        if (!done) check("op_timeout", 32'(done), 32'd1);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    // One idle cycle: returns rd_data and the OR of all strobes.
    task automatic idle_cycle(output logic [31:0] res, output logic [3:0] strobes);
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        res = rd_data;
        strobes = {sram_re, sram_we, mem_stall, mem_err};
        @(posedge clk); #1;
    endtask

    // Reference model from the access rules, byte by byte.
    task automatic model_op(input logic rd, input logic wr, input logic [8:0] a,
                            input logic [31:0] wd, input logic [2:0] f3,
                            output logic exp_err, output int exp_stalls, output int exp_we,
                            output int exp_re, output logic is_ld);
        int size, off, widx;
        logic st, ld, illegal;
        logic [31:0] w, v;
        st = wr; ld = rd && !wr;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
        off = int'(a) % 4;
        widx = int'(a) / 4;
        exp_err = (st || ld) && (illegal || (off % size) != 0);
        exp_stalls = 0; exp_we = 0; exp_re = 0; is_ld = 1'b0;
        if (exp_err) begin
            ref_held = 32'd0;
        end else if (st) begin
            w = ref_mem[widx];
            for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
            ref_mem[widx] = w;
            exp_we = 1;
            exp_stalls = (size == 4) ? 0 : 1;
            exp_re = exp_stalls;
        end else if (ld) begin
            v = 32'd0;
            w = ref_mem[widx];
            for (int i = 0; i < size; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
            if (f3 < 3'd4 && size < 4 && v[8*size-1])
                for (int j = 8*size; j < 32; j++) v[j] = 1'b1;
            ref_held = v;
            exp_stalls = 1; exp_re = 1; is_ld = 1'b1;
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        int          exp_stalls;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          stalls, we_cnt, re_cnt, e_stalls, e_we, e_re, tot;
        logic        err, overlap, e_err, is_ld;
        logic [31:0] res, res2;
        logic [6:0]  we_addr;
        logic [3:0]  strobes;
        logic        r_rd, r_wr;
        logic [8:0]  r_a;
        logic [31:0] r_wd;
        logic [2:0]  r_f3;

        vecs[0] = '{1'b1, 1'b0, 9'h00F, 32'h0, 3'd0, 32'hFFFFFF80, 1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 9'h00C, 32'h0, 3'd4, 32'h000000F3, 1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 9'h00E, 32'h0, 3'd1, 32'hFFFF8081, 1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 9'h00E, 32'h0, 3'd5, 32'h00008081, 1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 9'h00E, 32'h0, 3'd2, 32'h00000000, 0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 9'h000, 32'h0, 3'd3, 32'h00000000, 0, 1'b1};

        pre_en = 1'b0; pre_idx = 7'd0; pre_val = 32'd0;
        reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
        addr = 9'h00C; wr_data = 32'd0; func3 = 3'd2;

        // Reset dominates even with a request presented.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("reset_strobes", 32'({sram_re, sram_we, mem_stall, mem_err}), 32'd0);
            check("reset_rd_data", rd_data, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0; MemRead = 1'b0;

        for (int i = 0; i < 16; i++) preload(7'(i), $urandom);
        preload(7'd3, 32'h808182F3);

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].f3,
                  stalls, err, res, we_cnt, re_cnt, we_addr, overlap);
            check($sformatf("vec%0d_stalls", i), 32'(stalls), 32'(vecs[i].exp_stalls));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_re", i), 32'(re_cnt), vecs[i].exp_err ? 32'd0 : 32'd1);
            check($sformatf("vec%0d_we", i), 32'(we_cnt), 32'd0);
            if (!vecs[i].exp_err) check($sformatf("vec%0d_rd", i), res, vecs[i].exp_rd);
            idle_cycle(res2, strobes);
            check($sformatf("vec%0d_held", i), res2, vecs[i].exp_rd);
            check($sformatf("vec%0d_idle", i), 32'(strobes), 32'd0);
        end

        // Reset in RMW_MERGE aborts the halfword store.
        MemWrite = 1'b1; addr = 9'h00C; wr_data = 32'h0000BEEF; func3 = 3'd1;
        @(negedge clk);
        check("rmw_accept", 32'({sram_re, mem_stall}), 32'd3);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rmw_reset_strobes", 32'({sram_re, sram_we, mem_stall, mem_err}), 32'd0);
        check("rmw_reset_rd", rd_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; MemWrite = 1'b0;
        check("rmw_reset_word", sram_mem[3], 32'h808182F3);
        do_op(1'b1, 1'b0, 9'h00C, 32'd0, 3'd2, stalls, err, res, we_cnt, re_cnt, we_addr, overlap);
        check("after_reset_lw", res, 32'h808182F3);
        check("after_reset_stall", 32'(stalls), 32'd1);

        // Back-to-back LW / SW / LW.
        do_op(1'b1, 1'b0, 9'h00C, 32'd0, 3'd2, stalls, err, res, we_cnt, re_cnt, we_addr, overlap);
        tot = stalls;
        check("b2b_lw1", res, 32'h808182F3);
        do_op(1'b0, 1'b1, 9'h00C, 32'd0, 3'd2, stalls, err, res, we_cnt, re_cnt, we_addr, overlap);
        tot += stalls;
        check("b2b_sw_we", 32'(we_cnt), 32'd1);
        do_op(1'b1, 1'b0, 9'h00C, 32'd0, 3'd2, stalls, err, res, we_cnt, re_cnt, we_addr, overlap);
        tot += stalls;
        check("b2b_lw2", res, 32'h00000000);
        check("b2b_stalls", 32'(tot), 32'd2);
        ref_mem[3] = 32'd0;

        // Byte store through read-modify-write.
        preload(7'd3, 32'h808182F3);
        do_op(1'b0, 1'b1, 9'h00D, 32'h123456AA, 3'd0, stalls, err, res, we_cnt, re_cnt, we_addr, overlap);
        check("sb_stalls", 32'(stalls), 32'd1);
        check("sb_we", 32'(we_cnt), 32'd1);
        check("sb_overlap", 32'(overlap), 32'd0);
        check("sb_word", sram_mem[3], 32'h8081AAF3);
        ref_mem[3] = 32'h8081AAF3;

        // Zero-stall word store.
        do_op(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'd2, stalls, err, res, we_cnt, re_cnt, we_addr, overlap);
        check("sw_stalls", 32'(stalls), 32'd0);
        check("sw_we", 32'(we_cnt), 32'd1);
        check("sw_addr", 32'(we_addr), 32'd4);
        check("sw_word", sram_mem[4], 32'hDEADBEEF);
        ref_mem[4] = 32'hDEADBEEF;

        ref_held = 32'd0;
        for (int n = 0; n < 300; n++) begin
            r_rd = 1'($urandom_range(0, 1));
            r_wr = 1'($urandom_range(0, 1));
            r_a  = 9'($urandom_range(0, 63));
            r_wd = $urandom;
            r_f3 = 3'($urandom_range(0, 7));
            model_op(r_rd, r_wr, r_a, r_wd, r_f3, e_err, e_stalls, e_we, e_re, is_ld);
            do_op(r_rd, r_wr, r_a, r_wd, r_f3, stalls, err, res, we_cnt, re_cnt, we_addr, overlap);
            check("rnd_err", 32'(err), 32'(e_err));
            check("rnd_stalls", 32'(stalls), 32'(e_stalls));
            check("rnd_we", 32'(we_cnt), 32'(e_we));
            check("rnd_re", 32'(re_cnt), 32'(e_re));
            check("rnd_overlap", 32'(overlap), 32'd0);
            if (is_ld) check("rnd_load", res, ref_held);
            check("rnd_word", sram_mem[r_a[8:2]], ref_mem[r_a[8:2]]);
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle(res2, strobes);
                check("rnd_held", res2, ref_held);
                check("rnd_idle", 32'(strobes), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
